// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch-to-dispatch instruction buffer: machine width,
// buffer depth and the fetch packet layout.
package inst_buffer_pkg;

    localparam int N               = 3;
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);
    localparam int INST_BUF_SZ     = 16;

    typedef struct packed {
        logic       taken;
        logic [1:0] counter;
    } BP_PACKET;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic [31:0] predicted_PC;
        BP_PACKET    bp_packet;
    } FETCH_PACKET;

endpackage

// File: rtl/inst_buffer.sv
// N-wide circular FIFO between fetch and decode/dispatch; variable push and pop
// counts per cycle, whole-buffer flush on a branch-stack restore.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = INST_BUF_SZ
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_SCALAR_BITS-1:0]           fetch_valid_count,
    input  FETCH_PACKET [N-1:0]                  fetch_packets,
    output logic [NUM_SCALAR_BITS-1:0]           num_accepted,
    output logic [$clog2(DEPTH+1)-1:0]           buffer_spots,
    input  logic [NUM_SCALAR_BITS-1:0]           num_dispatched,
    input  logic                                 restore_valid,
    output FETCH_PACKET [N-1:0]                  out_packets,
    output logic [NUM_SCALAR_BITS-1:0]           instructions_valid
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    FETCH_PACKET               entry [DEPTH];
    logic [PTR_BITS-1:0]       head, tail;
    logic [CNT_BITS-1:0]       count;
    logic [NUM_SCALAR_BITS-1:0] pop;

    // Every output is a function of registered state (plus the fetch offer for
    // num_accepted); dispatch never feeds back into the fetch handshake.
    always_comb begin
        buffer_spots       = CNT_BITS'(DEPTH) - count;
        instructions_valid = (count > CNT_BITS'(N)) ? NUM_SCALAR_BITS'(N)
                                                    : NUM_SCALAR_BITS'(count);
        num_accepted = NUM_SCALAR_BITS'(min3(int'(fetch_valid_count), int'(buffer_spots), N));
        pop          = NUM_SCALAR_BITS'(min3(int'(num_dispatched), int'(instructions_valid), N));
        if (reset || restore_valid) begin
            num_accepted = '0;
            pop          = '0;
        end
        out_packets = '0;
        for (int i = 0; i < N; i++)
            if (i < int'(instructions_valid))
                out_packets[i] = entry[head + PTR_BITS'(i)];
    end

    always_ff @(posedge clock) begin
        if (reset || restore_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_BITS'(pop);
            tail  <= tail + PTR_BITS'(num_accepted);
            count <= count + CNT_BITS'(num_accepted) - CNT_BITS'(pop);
        end
    end

    // Storage carries no reset; num_accepted is already zero under reset/flush.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++)
            if (i < int'(num_accepted))
                entry[tail + PTR_BITS'(i)] <= fetch_packets[i];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count <= CNT_BITS'(DEPTH))
                else $error("inst_buffer: count %0d exceeds depth", count);
            assert (PTR_BITS'(tail - head) == PTR_BITS'(count))
                else $error("inst_buffer: pointer distance disagrees with count");
            assert (restore_valid || num_dispatched <= instructions_valid)
                else $error("inst_buffer: dispatched %0d with only %0d valid",
                            num_dispatched, instructions_valid);
            for (int i = 1; i < N; i++) begin
                assert (!(out_packets[i].valid && !out_packets[i-1].valid))
                    else $error("inst_buffer: out_packets valid bits not contiguous");
                assert (!(fetch_packets[i].valid && !fetch_packets[i-1].valid))
                    else $error("inst_buffer: fetch_packets valid bits not contiguous");
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized and directed bench for inst_buffer (N=3, DEPTH=8) against a
// queue-based reference model of the buffer contents.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CB    = $clog2(DEPTH + 1);

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic [NUM_SCALAR_BITS-1:0] fetch_valid_count = '0;
    FETCH_PACKET [N-1:0]        fetch_packets = '0;
    logic [NUM_SCALAR_BITS-1:0] num_accepted;
    logic [CB-1:0]              buffer_spots;
    logic [NUM_SCALAR_BITS-1:0] num_dispatched = '0;
    logic                       restore_valid = 1'b0;
    FETCH_PACKET [N-1:0]        out_packets;
    logic [NUM_SCALAR_BITS-1:0] instructions_valid;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .fetch_valid_count  (fetch_valid_count),
        .fetch_packets      (fetch_packets),
        .num_accepted       (num_accepted),
        .buffer_spots       (buffer_spots),
        .num_dispatched     (num_dispatched),
        .restore_valid      (restore_valid),
        .out_packets        (out_packets),
        .instructions_valid (instructions_valid)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int next_id = 0;
    bit chk_en = 1'b0;
    FETCH_PACKET model_q[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int pc_of(input int id);
        return 32'h1000 + id * 4;
    endfunction

    function automatic FETCH_PACKET mk(input int id);
        FETCH_PACKET p;
        p                   = '0;
        p.valid             = 1'b1;
        p.inst              = 32'h0000_0013 ^ (id << 7);
        p.PC                = pc_of(id);
        p.NPC               = pc_of(id) + 4;
        p.predicted_PC      = pc_of(id) + ((id % 5 == 0) ? 32'h40 : 32'h4);
        p.bp_packet.taken   = (id % 5 == 0);
        p.bp_packet.counter = 2'(id);
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    task automatic chk_pkt(input int idx, input FETCH_PACKET act, input FETCH_PACKET exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL out_packets[%0d]: got v=%0b pc=%h inst=%h, expected v=%0b pc=%h inst=%h at %0t",
                      idx, act.valid, act.PC, act.inst, exp.valid, exp.PC, exp.inst, $time);
    endtask

    // Reference model: the buffer is a program-ordered queue of packets.
    always @(posedge clock) begin
        automatic int sz = model_q.size();
        automatic int pop, acc;
        if (reset || restore_valid) begin
            model_q.delete();
        end else begin
            pop = imin(int'(num_dispatched), imin(sz, N));
            acc = imin(int'(fetch_valid_count), imin(DEPTH - sz, N));
            repeat (pop) void'(model_q.pop_front());
            for (int i = 0; i < acc; i++) model_q.push_back(fetch_packets[i]);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            automatic int sz = model_q.size();
            automatic int e_iv = imin(sz, N);
            automatic int e_acc = (reset || restore_valid) ? 0
                                : imin(int'(fetch_valid_count), imin(DEPTH - sz, N));
            chk("instructions_valid", int'(instructions_valid), e_iv);
            chk("buffer_spots", int'(buffer_spots), DEPTH - sz);
            chk("num_accepted", int'(num_accepted), e_acc);
            for (int i = 0; i < N; i++) begin
                automatic FETCH_PACKET e = '0;
                if (i < e_iv) e = model_q[i];
                chk_pkt(i, out_packets[i], e);
            end
        end
    end

    // Drives one cycle from just after a falling edge, samples num_accepted
    // mid-cycle, and returns at the next falling edge.
    task automatic cyc(input int fvc, input int nd, input bit rv, input bit rs, output int acc);
        #1;
        reset             = rs;
        restore_valid     = rv;
        num_dispatched    = NUM_SCALAR_BITS'(nd);
        fetch_valid_count = NUM_SCALAR_BITS'(fvc);
        for (int i = 0; i < N; i++) begin
            if (i < fvc) fetch_packets[i] = mk(next_id + i);
            else         fetch_packets[i] = '0;
        end
        next_id += N;
        #1 acc = int'(num_accepted);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int a, b;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_en = 1'b1;
        chk("reset iv", int'(instructions_valid), 0);
        chk("reset spots", int'(buffer_spots), 8);
        chk("reset out[0].PC", int'(out_packets[0].PC), 0);

        // Fill: 3 + 3 + 2, then nothing fits
        cyc(3, 0, 0, 0, a); chk("fill acc1", a, 3);
        cyc(3, 0, 0, 0, a); chk("fill acc2", a, 3);
        cyc(3, 0, 0, 0, a); chk("fill acc3", a, 2);
        chk("full spots", int'(buffer_spots), 0);
        chk("full out[0].PC", int'(out_packets[0].PC), pc_of(0));
        chk("full out[1].PC", int'(out_packets[1].PC), pc_of(1));
        chk("full out[2].PC", int'(out_packets[2].PC), pc_of(2));
        cyc(3, 0, 0, 0, a); chk("full acc", a, 0);

        // Drain across the pointer wrap while fetch keeps offering 3
        cyc(3, 3, 0, 0, a); chk("drain acc from full", a, 0);
        chk("drain out[0].PC", int'(out_packets[0].PC), pc_of(3));
        repeat (9) cyc(3, 3, 0, 0, a);

        // Partial dispatch from count 5
        cyc(0, 0, 1, 0, a);
        b = next_id;
        cyc(3, 0, 0, 0, a);
        cyc(2, 0, 0, 0, a);
        chk("partial spots before", int'(buffer_spots), 3);
        cyc(0, 1, 0, 0, a);
        chk("partial out[0].PC", int'(out_packets[0].PC), pc_of(b + 1));
        chk("partial iv", int'(instructions_valid), 3);
        chk("partial spots", int'(buffer_spots), 4);

        // Flush beats a simultaneous push
        cyc(0, 0, 1, 0, a);
        cyc(3, 0, 0, 0, a);
        cyc(3, 0, 0, 0, a);
        chk("pre-flush spots", int'(buffer_spots), 2);
        cyc(3, 0, 1, 0, a); chk("flush acc", a, 0);
        chk("flush iv", int'(instructions_valid), 0);
        chk("flush spots", int'(buffer_spots), 8);
        b = next_id;
        cyc(1, 0, 0, 0, a);
        chk("post-flush iv", int'(instructions_valid), 1);
        chk("post-flush out[0].PC", int'(out_packets[0].PC), pc_of(b));

        // Under-occupancy
        cyc(0, 0, 1, 0, a);
        cyc(2, 0, 0, 0, a);
        chk("under iv", int'(instructions_valid), 2);
        chk("under out[2].valid", int'(out_packets[2].valid), 0);
        chk("under out[2].PC", int'(out_packets[2].PC), 0);
        cyc(0, 2, 0, 0, a);
        chk("under drained spots", int'(buffer_spots), 8);

        // Reset mid-stream overrides push
        cyc(0, 0, 1, 0, a);
        cyc(3, 0, 0, 0, a);
        cyc(1, 0, 0, 0, a);
        chk("pre-reset spots", int'(buffer_spots), 4);
        cyc(3, 0, 0, 1, a); chk("reset acc", a, 0);
        chk("post-reset iv", int'(instructions_valid), 0);
        chk("post-reset spots", int'(buffer_spots), 8);
        chk("post-reset out[0].PC", int'(out_packets[0].PC), 0);

        // Random traffic; legal dispatch counts, occasional flush/reset
        for (int k = 0; k < 400; k++) begin
            automatic bit rv = ($urandom_range(0, 19) == 0);
            automatic bit rs = ($urandom_range(0, 59) == 0);
            automatic int nd = rv ? $urandom_range(0, N)
                                  : $urandom_range(0, imin(model_q.size(), N));
            cyc($urandom_range(0, N), nd, rv, rs, a);
        end
        cyc(0, 0, 0, 0, a);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
